jedro_1_lsu: RTL and testbench

// - Load-store unit between the execute stage and the byte-writable data RAM.
// - Takes one load/store request at a time and drives one RAM access with per-byte

---
 rtl/jedro_1_lsu.sv | 179 +++++++++++++++++
 tb/tb_jedro_1_lsu.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/jedro_1_lsu.sv
// rtl/jedro_1_lsu.sv - load-store unit with byte-lane RAM access, 3-cycle blocking FSM
// Optional misaligned/illegal request reporting: define JEDRO_1_LSU_MISALIGN_EXC_EN.
module jedro_1_lsu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o,
  output logic                  ram_en_o,
  output logic [3:0]            ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_we;
  logic                    r_unsigned;
  logic                    r_err;
  logic [1:0]              r_size;
  logic [1:0]              r_off;
  logic [3:0]              r_be;
  logic [ADDR_WIDTH-3:0]   r_waddr;
  logic [DATA_WIDTH-1:0]   r_wdata;

  logic [1:0]              w_size;
  logic                    w_unsigned;
  logic [1:0]              w_off;
  logic [3:0]              w_be;
  logic [DATA_WIDTH-1:0]   w_wdata;
  logic                    w_err;
  logic                    w_accept;
  logic [DATA_WIDTH-1:0]   w_shifted;
  logic [DATA_WIDTH-1:0]   w_ext;

  // Width decode; unknown codes fall back to a word access
  always_comb begin
    w_size     = SZ_W;
    w_unsigned = 1'b0;
    if (req_we_i) begin
      case (req_funct3_i)
        3'b000:  w_size = SZ_B;
        3'b001:  w_size = SZ_H;
        default: w_size = SZ_W;
      endcase
    end else begin
      case (req_funct3_i)
        3'b000:  w_size = SZ_B;
        3'b001:  w_size = SZ_H;
        3'b100:  begin w_size = SZ_B; w_unsigned = 1'b1; end
        3'b101:  begin w_size = SZ_H; w_unsigned = 1'b1; end
        default: w_size = SZ_W;
      endcase
    end
  end

`ifdef JEDRO_1_LSU_MISALIGN_EXC_EN
  always_comb begin
    w_err = 1'b0;
    if (req_we_i) begin
      w_err = (req_funct3_i != 3'b000) && (req_funct3_i != 3'b001) && (req_funct3_i != 3'b010);
    end else begin
      w_err = (req_funct3_i == 3'b011) || (req_funct3_i == 3'b110) || (req_funct3_i == 3'b111);
    end
    if (w_size == SZ_H && req_addr_i[0]) w_err = 1'b1;
    if (w_size == SZ_W && req_addr_i[1:0] != 2'b00) w_err = 1'b1;
  end
`else
  assign w_err = 1'b0;
`endif

  // Halfwords snap to a[1], words to lane 0
  always_comb begin
    w_off   = 2'b00;
    w_be    = 4'b1111;
    w_wdata = req_wdata_i;
    case (w_size)
      SZ_B: begin
        w_off   = req_addr_i[1:0];
        w_be    = 4'b0001 << req_addr_i[1:0];
        w_wdata = {4{req_wdata_i[7:0]}};
      end
      SZ_H: begin
        w_off   = {req_addr_i[1], 1'b0};
        w_be    = req_addr_i[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{req_wdata_i[15:0]}};
      end
      default: begin
        w_off   = 2'b00;
        w_be    = 4'b1111;
        w_wdata = req_wdata_i;
      end
    endcase
  end

  assign w_accept = (r_state == IDLE) && req_valid_i;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state    <= IDLE;
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_err      <= 1'b0;
      r_size     <= SZ_W;
      r_off      <= 2'b00;
      r_be       <= 4'b0000;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we       <= req_we_i;
        r_unsigned <= w_unsigned;
        r_err      <= w_err;
        r_size     <= w_size;
        r_off      <= w_off;
        r_be       <= req_we_i ? w_be : 4'b0000;
        r_waddr    <= req_addr_i[ADDR_WIDTH-1:2];
        r_wdata    <= w_wdata;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req_valid_i) w_next = ACCESS;
      ACCESS:  w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Load alignment: halfword offsets are 0 or 2, so 8*off also covers 16*a[1]
  assign w_shifted = ram_rdata_i >> {r_off, 3'b000};

  always_comb begin
    w_ext = w_shifted;
    case (r_size)
      SZ_B:    w_ext = r_unsigned ? {24'b0, w_shifted[7:0]}
                                  : {{24{w_shifted[7]}}, w_shifted[7:0]};
      SZ_H:    w_ext = r_unsigned ? {16'b0, w_shifted[15:0]}
                                  : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default: w_ext = w_shifted;
    endcase
  end

  // RAM strobes are gated by rstn_i so a reset cycle never commits a write
  assign req_ready_o = (r_state == IDLE);
  assign ram_en_o    = (r_state == ACCESS) && !r_err && rstn_i;
  assign ram_we_o    = ram_en_o ? r_be : 4'b0000;
  assign ram_addr_o  = {r_waddr, 2'b00};
  assign ram_wdata_o = r_wdata;
  assign done_o      = (r_state == RESP);
  assign rdata_o     = (done_o && !r_we && !r_err) ? w_ext : '0;

`ifdef JEDRO_1_LSU_MISALIGN_EXC_EN
  assign err_o = done_o && r_err;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_jedro_1_lsu.sv
// tb/tb_jedro_1_lsu.sv - directed bench for jedro_1_lsu with a byte-writable RAM model
module tb_jedro_1_lsu;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        done_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        ram_en_o;
  logic [3:0]  ram_we_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i = 32'h0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [0:15];

  logic        acc_en, acc_done;
  logic [3:0]  acc_we;
  logic [31:0] acc_addr, acc_wdata;
  logic        rsp_done, rsp_err;
  logic [31:0] rsp_rdata;

  jedro_1_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_funct3_i (req_funct3_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .done_o       (done_o),
    .rdata_o      (rdata_o),
    .err_o        (err_o),
    .ram_en_o     (ram_en_o),
    .ram_we_o     (ram_we_o),
    .ram_addr_o   (ram_addr_o),
    .ram_wdata_o  (ram_wdata_o),
    .ram_rdata_i  (ram_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (ram_en_o) begin
      for (int i = 0; i < 4; i++)
        if (ram_we_o[i]) mem[ram_addr_o[5:2]][8*i +: 8] <= ram_wdata_o[8*i +: 8];
      ram_rdata_i <= mem[ram_addr_o[5:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One request from IDLE; samples the ACCESS cycle and the RESP cycle
  task automatic xfer(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata);
    @(negedge clk_i);
    req_valid_i  = 1'b1;
    req_we_i     = we;
    req_funct3_i = f3;
    req_addr_i   = addr;
    req_wdata_i  = wdata;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    acc_en    = ram_en_o;
    acc_we    = ram_we_o;
    acc_addr  = ram_addr_o;
    acc_wdata = ram_wdata_o;
    acc_done  = done_o;
    @(negedge clk_i);
    rsp_done  = done_o;
    rsp_err   = err_o;
    rsp_rdata = rdata_o;
  endtask

  initial begin
    logic       rdy;
    int         idx;
    int         n_done;
    logic [31:0] s_addr [0:2];
    logic [31:0] s_data [0:2];

    rstn_i = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0;
    req_funct3_i = 3'b000; req_addr_i = 32'h0; req_wdata_i = 32'h0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ready", {31'b0, req_ready_o}, 32'h1);
    chk("rst_done",  {31'b0, done_o}, 32'h0);
    chk("rst_err",   {31'b0, err_o}, 32'h0);
    chk("rst_en",    {31'b0, ram_en_o}, 32'h0);
    chk("rst_we",    {28'b0, ram_we_o}, 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_addr",  ram_addr_o, 32'h0);
    chk("rst_wdata", ram_wdata_o, 32'h0);
    rstn_i = 1'b1;

    xfer(1'b1, 3'b010, 32'h0, 32'h0);
    chk("sw0_en", {31'b0, acc_en}, 32'h1);
    chk("sw0_we", {28'b0, acc_we}, 32'hF);
    xfer(1'b1, 3'b010, 32'h4, 32'h0);
    xfer(1'b1, 3'b010, 32'h8, 32'h0);
    chk("zero_mem1", mem[1], 32'h0);

    xfer(1'b1, 3'b000, 32'h0, 32'hFFFFFFFF);
    chk("sb0_we",     {28'b0, acc_we}, 32'h1);
    chk("sb0_wdata",  acc_wdata, 32'hFFFFFFFF);
    chk("sb0_nodone", {31'b0, acc_done}, 32'h0);
    chk("sb0_done",   {31'b0, rsp_done}, 32'h1);
    chk("sb0_rdata",  rsp_rdata, 32'h0);
    chk("sb0_mem",    mem[0], 32'h000000FF);

    xfer(1'b1, 3'b000, 32'h5, 32'h000000AB);
    chk("sb5_we",    {28'b0, acc_we}, 32'h2);
    chk("sb5_addr",  acc_addr, 32'h4);
    chk("sb5_wdata", acc_wdata, 32'hABABABAB);
    chk("sb5_mem",   mem[1], 32'h0000AB00);

    xfer(1'b1, 3'b001, 32'h2, 32'h00001234);
    chk("sh2_we",    {28'b0, acc_we}, 32'hC);
    chk("sh2_wdata", acc_wdata, 32'h12341234);
    chk("sh2_mem",   mem[0], 32'h123400FF);

    xfer(1'b0, 3'b001, 32'h2, 32'h0);
    chk("lh2",      rsp_rdata, 32'h00001234);
    chk("lh2_we",   {28'b0, acc_we}, 32'h0);
    xfer(1'b0, 3'b010, 32'h0, 32'h0);
    chk("lw0",      rsp_rdata, 32'h123400FF);
    xfer(1'b0, 3'b000, 32'h3, 32'h0);
    chk("lb3",      rsp_rdata, 32'h00000012);
    xfer(1'b0, 3'b100, 32'h0, 32'h0);
    chk("lbu0",     rsp_rdata, 32'h000000FF);
    xfer(1'b0, 3'b000, 32'h0, 32'h0);
    chk("lb0",      rsp_rdata, 32'hFFFFFFFF);

    xfer(1'b1, 3'b010, 32'h8, 32'h00008080);
    xfer(1'b0, 3'b000, 32'h8, 32'h0);
    chk("lb8",   rsp_rdata, 32'hFFFFFF80);
    xfer(1'b0, 3'b100, 32'h8, 32'h0);
    chk("lbu8",  rsp_rdata, 32'h00000080);
    xfer(1'b0, 3'b001, 32'h8, 32'h0);
    chk("lh8",   rsp_rdata, 32'hFFFF8080);
    xfer(1'b0, 3'b101, 32'hA, 32'h0);
    chk("lhuA",  rsp_rdata, 32'h00000000);

    xfer(1'b0, 3'b010, 32'h2, 32'h0);
    chk("lw2_done", {31'b0, rsp_done}, 32'h1);
`ifdef JEDRO_1_LSU_MISALIGN_EXC_EN
    chk("lw2_err",   {31'b0, rsp_err}, 32'h1);
    chk("lw2_en",    {31'b0, acc_en}, 32'h0);
    chk("lw2_rdata", rsp_rdata, 32'h0);
`else
    chk("lw2_err",   {31'b0, rsp_err}, 32'h0);
    chk("lw2_en",    {31'b0, acc_en}, 32'h1);
    chk("lw2_rdata", rsp_rdata, 32'h123400FF);
`endif

    // Back-to-back SW stream with valid held high
    s_addr[0] = 32'h20; s_data[0] = 32'h11111111;
    s_addr[1] = 32'h24; s_data[1] = 32'h22222222;
    s_addr[2] = 32'h28; s_data[2] = 32'h33333333;
    @(negedge clk_i);
    idx = 0; n_done = 0;
    req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = 3'b010;
    req_addr_i = s_addr[0]; req_wdata_i = s_data[0];
    for (int k = 0; k < 9; k++) begin
      rdy = req_ready_o;
      if (done_o) n_done++;
      chk($sformatf("stream_rdy%0d", k), {31'b0, rdy}, {31'b0, (k % 3) == 0});
      @(negedge clk_i);
      if (rdy && req_valid_i) begin
        idx++;
        if (idx < 3) begin
          req_addr_i = s_addr[idx]; req_wdata_i = s_data[idx];
        end else begin
          req_valid_i = 1'b0;
        end
      end
    end
    chk("stream_accepts", idx, 32'd3);
    chk("stream_dones", n_done, 32'd3);
    chk("stream_mem8",  mem[8],  32'h11111111);
    chk("stream_mem9",  mem[9],  32'h22222222);
    chk("stream_mem10", mem[10], 32'h33333333);

    // Reset during the ACCESS cycle of a store
    req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = 3'b010;
    req_addr_i = 32'h0; req_wdata_i = 32'hDEADBEEF;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    rstn_i = 1'b0;
    #1;
    chk("rstacc_en", {31'b0, ram_en_o}, 32'h0);
    chk("rstacc_we", {28'b0, ram_we_o}, 32'h0);
    @(posedge clk_i);
    @(negedge clk_i);
    rstn_i = 1'b1;
    chk("rstacc_done",  {31'b0, done_o}, 32'h0);
    chk("rstacc_ready", {31'b0, req_ready_o}, 32'h1);
    @(negedge clk_i);
    chk("rstacc_done2", {31'b0, done_o}, 32'h0);
    chk("rstacc_mem",   mem[0], 32'h123400FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
